// File: rtl/arbiter_pkg.sv
// Shared defaults for the weighted round-robin arbiter and its per-port FIFOs.
package arbiter_pkg;
  localparam int ARB_NUM_PORTS    = 8;
  localparam int ARB_WIDTH        = 8;
  localparam int ARB_DEPTH        = 4;
  localparam int ARB_WEIGHT_W     = 3;
  localparam int ARB_RESET_WEIGHT = 1;
endpackage

// File: rtl/arb_fifo.sv
// Per-port buffer: WIDTH x DEPTH circular FIFO with registered occupancy count.
module arb_fifo
  import arbiter_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH,
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is dropped even if the same cycle pops.
  assign wr_en       = push && !full;
  assign rd_en       = pop && (count != '0);
  assign dout        = mem[rd_ptr];
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: per-port FIFOs drained one word per cycle into
// a stallable output register, each port getting <weight> consecutive grants.
module wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = ARB_NUM_PORTS,
  parameter int WIDTH     = ARB_WIDTH,
  parameter int DEPTH     = ARB_DEPTH,
  parameter int WEIGHT_W  = ARB_WEIGHT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [0:NUM_PORTS-1]         push,
  input  logic [NUM_PORTS*WIDTH-1:0]   d,
  output logic [0:NUM_PORTS-1]         full,
  output logic [0:NUM_PORTS-1]         almost_full,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_PORTS)-1:0] cfg_port,
  input  logic [WEIGHT_W-1:0]          cfg_weight,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(NUM_PORTS)-1:0] src,
  output logic                         valid,
  input  logic                         stall
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       fifo_count [NUM_PORTS];
  logic [WIDTH-1:0]    head       [NUM_PORTS];
  logic [WEIGHT_W-1:0] weight     [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] pop;
  logic [PW-1:0]       cur;
  logic [PW-1:0]       grant_idx;
  logic [WEIGHT_W-1:0] credit;
  logic                load;
  logic                grant_ok;
  logic                reload;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    arb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push[i]),
      .pop         (pop[i]),
      .din         (d[(NUM_PORTS-i)*WIDTH-1 -: WIDTH]),
      .dout        (head[i]),
      .count       (fifo_count[i]),
      .full        (full[i]),
      .almost_full (almost_full[i])
    );
    assign elig[i] = (fifo_count[i] != '0) && (weight[i] != '0);
    assign pop[i]  = load && grant_ok && (grant_idx == PW'(i));
  end

  // Stall only matters while the output register actually holds a word.
  assign load = !valid || !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) weight[i] <= WEIGHT_W'(ARB_RESET_WEIGHT);
    end else if (cfg_we) begin
      weight[cfg_port] <= cfg_weight;
    end
  end

  // Stay on cur while it has credit; otherwise scan forward from cur+1,
  // wrapping, with cur itself considered last.
  always_comb begin
    grant_ok  = 1'b0;
    reload    = 1'b0;
    grant_idx = cur;
    if (elig[cur] && (credit != '0)) begin
      grant_ok = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!grant_ok && elig[PW'((int'(cur) + k) % NUM_PORTS)]) begin
          grant_ok  = 1'b1;
          reload    = 1'b1;
          grant_idx = PW'((int'(cur) + k) % NUM_PORTS);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      src    <= '0;
      valid  <= 1'b0;
      cur    <= '0;
      credit <= '0;
    end else if (load) begin
      if (grant_ok) begin
        q     <= head[grant_idx];
        src   <= grant_idx;
        valid <= 1'b1;
        if (reload) begin
          cur    <= grant_idx;
          credit <= weight[grant_idx] - WEIGHT_W'(1);
        end else begin
          credit <= credit - WEIGHT_W'(1);
        end
      end else begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed vectors plus a queue-based reference model.
module tb_wrr_arbiter;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int WW = 3;

  logic           clk = 1'b0;
  bit             clk_en = 1'b0;
  logic           rst;
  logic [0:N-1]   push;
  logic [N*W-1:0] d;
  logic [0:N-1]   full;
  logic [0:N-1]   almost_full;
  logic           cfg_we;
  logic [2:0]     cfg_port;
  logic [WW-1:0]  cfg_weight;
  logic [W-1:0]   q;
  logic [2:0]     src;
  logic           valid;
  logic           stall;

  int n_checks = 0;
  int n_fail   = 0;

  wrr_arbiter #(.NUM_PORTS(N), .WIDTH(W), .DEPTH(D), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .d           (d),
    .full        (full),
    .almost_full (almost_full),
    .cfg_we      (cfg_we),
    .cfg_port    (cfg_port),
    .cfg_weight  (cfg_weight),
    .q           (q),
    .src         (src),
    .valid       (valid),
    .stall       (stall)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: one queue per port plus the grant-pointer/credit rules.
  logic [W-1:0] mq [N][$];
  int           m_w [N];
  int           m_cur, m_credit, m_src;
  bit           m_valid;
  logic [W-1:0] m_q;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_w[i] = 1;
    end
    m_cur = 0; m_credit = 0; m_valid = 0; m_q = '0; m_src = 0;
  endtask

  function automatic bit m_elig(int p);
    return (mq[p].size() > 0) && (m_w[p] != 0);
  endfunction

  task automatic model_step();
    bit acc [N];
    int g;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) acc[i] = push[i] && (mq[i].size() < D);
    if (!m_valid || !stall) begin
      g = -1;
      if (m_elig(m_cur) && m_credit > 0) begin
        g = m_cur;
        m_credit--;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && m_elig((m_cur + k) % N)) begin
            g = (m_cur + k) % N;
            m_cur = g;
            m_credit = m_w[g] - 1;
          end
        end
      end
      if (g >= 0) begin
        m_q = mq[g].pop_front();
        m_src = g;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(d[(N-1-i)*W +: W]);
    if (cfg_we) m_w[int'(cfg_port)] = int'(cfg_weight);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_d(int p, logic [W-1:0] v);
    d[(N-1-p)*W +: W] = v;
  endtask

  task automatic idle_inputs();
    push = '0; d = '0; cfg_we = 0; cfg_port = '0; cfg_weight = '0; stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #1;
    model_reset();
    tick();
    rst = 1;
  endtask

  task automatic check_model(string tag);
    logic [0:N-1] ef, ea;
    for (int i = 0; i < N; i++) begin
      ef[i] = (mq[i].size() == D);
      ea[i] = (mq[i].size() >= D - 1);
    end
    chk({tag, " valid"}, valid, m_valid);
    if (m_valid) begin
      chk({tag, " q"}, q, m_q);
      chk({tag, " src"}, src, m_src);
    end
    chk({tag, " full"}, full, ef);
    chk({tag, " almost_full"}, almost_full, ea);
  endtask

  // Port 0 dummy word 0xAA is granted and then parked under stall; ports 0..2
  // are then filled with four words each.
  task automatic rr_setup();
    logic [0:N-1] ef;
    push = '0; push[0] = 1; set_d(0, 8'hAA); stall = 1;
    tick();
    push = '0;
    tick();
    chk("rr dummy valid", valid, 1);
    chk("rr dummy q", q, 8'hAA);
    for (int n = 0; n < 4; n++) begin
      push = '0; push[0] = 1; push[1] = 1; push[2] = 1;
      set_d(0, W'(8'h10 + n)); set_d(1, W'(8'h20 + n)); set_d(2, W'(8'h30 + n));
      tick();
      chk($sformatf("rr hold q %0d", n), q, 8'hAA);
    end
    push = '0;
    ef = '0; ef[0] = 1; ef[1] = 1; ef[2] = 1;
    chk("rr loaded full", full, ef);
  endtask

  typedef struct {
    bit           push0;
    logic [W-1:0] din;
    bit           exp_valid;
    logic [W-1:0] exp_q;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tbl [10];
    logic [0:N-1] ev;
    int           p;

    for (int i = 0; i < 10; i++) begin
      tbl[i].push0     = (i < 8);
      tbl[i].din       = W'(i);
      tbl[i].exp_valid = (i >= 1) && (i <= 8);
      tbl[i].exp_q     = (i == 0) ? W'(0) : ((i > 8) ? W'(7) : W'(i - 1));
    end

    // Reset with the clock stopped, then running.
    idle_inputs();
    rst = 0;
    model_reset();
    #3;
    chk("rst stopped full", full, 0);
    chk("rst stopped almost_full", almost_full, 0);
    chk("rst stopped valid", valid, 0);
    chk("rst stopped q", q, 0);
    chk("rst stopped src", src, 0);
    clk_en = 1;
    push = '1; d = '1;
    tick(); tick();
    chk("rst running full", full, 0);
    chk("rst running almost_full", almost_full, 0);
    chk("rst running valid", valid, 0);
    chk("rst running q", q, 0);
    chk("rst running src", src, 0);
    idle_inputs();
    rst = 1;
    tick();

    // Streaming from port 0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push = '0; push[0] = tbl[i].push0; set_d(0, tbl[i].din);
      tick();
      chk($sformatf("stream valid %0d", i), valid, tbl[i].exp_valid);
      chk($sformatf("stream q %0d", i), q, tbl[i].exp_q);
      if (tbl[i].exp_valid) chk($sformatf("stream src %0d", i), src, 0);
      chk($sformatf("stream full %0d", i), full[0], 0);
    end

    // Round robin over ports 0..2 at weight 1.
    do_reset();
    rr_setup();
    stall = 0;
    for (int j = 0; j < 12; j++) begin
      p = (j % 3 == 0) ? 1 : ((j % 3 == 1) ? 2 : 0);
      tick();
      chk($sformatf("rr valid %0d", j), valid, 1);
      chk($sformatf("rr src %0d", j), src, p);
      chk($sformatf("rr q %0d", j), q, W'((p + 1) * 16 + j / 3));
    end
    tick();
    chk("rr drained valid", valid, 0);

    // Weights 3:1 on ports 0 and 1.
    do_reset();
    cfg_we = 1; cfg_port = 0; cfg_weight = 3;
    tick();
    cfg_we = 0;
    for (int j = -1; j < 12; j++) begin
      push = '0; push[0] = 1; push[1] = 1;
      set_d(0, W'(8'h40 + j + 1)); set_d(1, W'(8'h50 + j + 1));
      tick();
      if (j >= 0) begin
        chk($sformatf("wt valid %0d", j), valid, 1);
        chk($sformatf("wt src %0d", j), src, (j % 4 == 0) ? 1 : 0);
      end
    end
    push = '0;

    // Back-pressure and full on port 3.
    do_reset();
    push = '0; push[0] = 1; set_d(0, 8'hAA); stall = 1;
    tick();
    push = '0;
    tick();
    for (int n = 0; n < 5; n++) begin
      push = '0; push[3] = 1; set_d(3, W'(8'h60 + n));
      tick();
      chk($sformatf("bp almost_full %0d", n), almost_full[3], n >= 2);
      chk($sformatf("bp full %0d", n), full[3], n >= 3);
      chk($sformatf("bp q held %0d", n), q, 8'hAA);
      chk($sformatf("bp valid held %0d", n), valid, 1);
    end
    push = '0; stall = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("bp drain q %0d", j), q, W'(8'h60 + j));
      chk($sformatf("bp drain src %0d", j), src, 3);
      if (j == 0) chk("bp full after pop", full[3], 0);
    end
    tick();
    chk("bp fifth dropped", valid, 0);

    // Async reset in the middle of a burst, with port 1 weight raised first.
    do_reset();
    cfg_we = 1; cfg_port = 1; cfg_weight = 3;
    tick();
    cfg_we = 0;
    rr_setup();
    stall = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_model($sformatf("burst %0d", j));
    end
    #2;
    rst = 0;
    #1;
    model_reset();
    chk("async valid", valid, 0);
    chk("async q", q, 0);
    chk("async src", src, 0);
    chk("async full", full, 0);
    chk("async almost_full", almost_full, 0);
    tick();
    rst = 1;
    tick();
    chk("post reset empty", valid, 0);
    for (int n = 0; n < 2; n++) begin
      push = '0; push[0] = 1; push[1] = 1;
      set_d(0, W'(8'h70 + n)); set_d(1, W'(8'h80 + n));
      tick();
      if (n == 1) begin
        chk("post reset src A", src, 1);
        chk("post reset q A", q, 8'h80);
      end
    end
    push = '0;
    tick();
    chk("post reset src B", src, 0);
    chk("post reset q B", q, 8'h70);
    tick();
    chk("post reset src C", src, 1);
    chk("post reset q C", q, 8'h81);
    tick();
    chk("post reset src D", src, 0);
    chk("post reset q D", q, 8'h71);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        push[i] = ($urandom_range(0, 2) == 0);
        set_d(i, W'($urandom));
      end
      stall      = ($urandom_range(0, 3) == 0);
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_port   = 3'($urandom_range(0, N - 1));
      cfg_weight = WW'($urandom_range(0, 7));
      tick();
      check_model($sformatf("rand %0d", c));
    end
    idle_inputs();
    for (int c = 0; c < 40; c++) begin
      tick();
      check_model($sformatf("rand drain %0d", c));
    end

    ev = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, number of requesters.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per port.
REQ-003 SHALL have parameter DEPTH, default 4, entries per port FIFO (power of 2).
REQ-004 SHALL have parameter WEIGHT_W, default 3, weight field bits.
REQ-005 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-007 SHALL have port push  in  [0:NUM_PORTS-1]  per-port write strobe, bit 0 = port 0.
REQ-008 SHALL have port d  in  NUM_PORTS*WIDTH  write data; port i at d[(NUM_PORTS-i)*WIDTH-1 -: WIDTH], so port 0 = top byte.
REQ-009 SHALL have port full  out  [0:NUM_PORTS-1]  per-port FIFO count == DEPTH.
REQ-010 SHALL have port almost_full  out  [0:NUM_PORTS-1]  per-port count >= DEPTH-1.
REQ-011 SHALL have ports cfg_we  in  1, cfg_port  in  clog2(NUM_PORTS), cfg_weight  in  WEIGHT_W; weight write.
REQ-012 SHALL have port q  out  WIDTH  granted data word.
REQ-013 SHALL have port src  out  clog2(NUM_PORTS)  port index that produced q.
REQ-014 SHALL have port valid  out  1  q/src hold a word.
REQ-015 SHALL have port stall  in  1  downstream back-pressure.

Function
REQ-016 SHALL write d slice into port i FIFO when push[i]=1 and full[i]=0; push while full drops the word, no state change.
REQ-017 SHALL update full/almost_full from registered counts; same-cycle push+pop on one non-full port leaves count unchanged.
REQ-018 SHALL load the output register (q, src, valid) when valid=0 or stall=0; else hold q, src, valid unchanged.
REQ-019 SHALL ignore stall when valid=0.
REQ-020 SHALL, at each load opportunity, grant current pointer cur if its FIFO is non-empty, its weight is non-zero and credit>0; pop it, decrement credit.
REQ-021 SHALL otherwise search cur+1, cur+2, ... wrapping NUM_PORTS-1 -> 0 and ending at cur, grant first non-empty port with weight != 0, set cur to it, set credit = weight-1.
REQ-022 SHALL, if no port is eligible at a load opportunity, load valid=0 (q, src keep last values).
REQ-023 SHALL give latency: push sampled at edge k on an idle block -> valid=1 after edge k+1.
REQ-024 SHALL sustain one word per cycle while stall=0 and any port is eligible.
REQ-025 SHALL treat weight 0 as port disabled (data retained, never granted).
REQ-026 SHALL apply a cfg write at the next edge; a new weight for cur affects only the next credit reload, not remaining credit.
REQ-027 SHALL preserve per-port FIFO order; no word duplicated or lost except REQ-016 drops.

Reset
REQ-028 SHALL, while rst=0, immediately force: all FIFOs empty, full=0, almost_full=0, valid=0, q=0, src=0, cur=0, credit=0, all weights=1.
REQ-029 SHALL, on reset mid-operation, discard all buffered and output words; first post-reset grant follows REQ-021 from cur=0 (search begins at port 1, port 0 last).

Structure
REQ-030 SHALL place NUM_PORTS/WIDTH/DEPTH/WEIGHT_W defaults and the reset weight constant in shared package arbiter_pkg.
REQ-031 SHALL instantiate sub-module arb_fifo (WIDTH x DEPTH, push/pop/count/full/almost_full) once per port; scheduler and output register stay in wrr_arbiter.

Verification
REQ-032 SHALL check reset: rst=0 -> full=00, almost_full=00, valid=0, q=00, src=0 with clk stopped and running.
REQ-033 SHALL check streaming: port 0 pushes 0..7 on 8 consecutive cycles, stall=0 -> q=0..7 consecutive, src=0, full never 1.
REQ-034 SHALL check round-robin: stall=1, ports 0,1,2 each loaded with 4 words (values 0x10+n, 0x20+n, 0x30+n), weights 1, release stall -> src sequence 1,2,0,1,2,0,... first word from port 1 (per REQ-029 search order), 12 words, no gaps.
REQ-035 SHALL check weights: cfg weight port0=3, port1=1, both kept non-empty -> src pattern 0,0,0,1 repeating.
REQ-036 SHALL check back-pressure/full: valid=1, stall=1, port 3 pushes 5 words -> almost_full[3]=1 after 3rd, full[3]=1 after 4th, 5th dropped, q held stable.
REQ-037 SHALL check async reset mid-burst: rst=0 between edges during REQ-034 -> valid=0 before next edge, FIFOs empty, weights back to 1.
